// File: rtl/dde_detail_enhance_if.sv
// Pixel-stream bundle for the DDE detail-enhance back end: original stream,
// Gaussian base stream, per-frame controls, enhanced output and FIFO status.
interface dde_detail_enhance_if #(
  parameter int DW     = 14,
  parameter int GAIN_W = 8
);
  logic              i_field_vld;
  logic              i_line_vld;
  logic [DW-1:0]     i_img_data;
  logic              i_base_field_vld;
  logic              i_base_line_vld;
  logic [DW-1:0]     i_base_data;
  logic [GAIN_W-1:0] i_detail_gain;
  logic [DW-1:0]     i_noise_thr;
  logic              o_field_vld;
  logic              o_line_vld;
  logic [DW-1:0]     o_img_data;
  logic              o_fifo_ovf;
  logic              o_fifo_udf;

  modport master (
    output i_field_vld, i_line_vld, i_img_data,
    output i_base_field_vld, i_base_line_vld, i_base_data,
    output i_detail_gain, i_noise_thr,
    input  o_field_vld, o_line_vld, o_img_data, o_fifo_ovf, o_fifo_udf
  );

  modport slave (
    input  i_field_vld, i_line_vld, i_img_data,
    input  i_base_field_vld, i_base_line_vld, i_base_data,
    input  i_detail_gain, i_noise_thr,
    output o_field_vld, o_line_vld, o_img_data, o_fifo_ovf, o_fifo_udf
  );
endinterface

// File: rtl/dde_detail_enhance.sv
// DDE back end: aligns original pixels with their Gaussian base in a FIFO,
// then cores, amplifies and re-adds the detail (orig - base) with clipping.
module dde_detail_enhance #(
  parameter int DW          = 14,
  parameter int ALIGN_DEPTH = 1024,
  parameter int AW          = 10,
  parameter int GAIN_W      = 8,
  parameter int GAIN_FRAC   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  dde_detail_enhance_if.slave  bus
);

  localparam int PW = DW + GAIN_W + 2;
  localparam logic signed [PW-1:0] RND     = PW'(1 << (GAIN_FRAC - 1));
  localparam logic signed [PW:0]   PIX_MAX = (PW+1)'((1 << DW) - 1);

  // ---------------- frame start and per-frame controls ----------------
  logic              field_d;
  logic              frame_start;
  logic [GAIN_W-1:0] gain_q;
  logic [DW-1:0]     thr_q;

  assign frame_start = bus.i_field_vld & ~field_d;

  // ---------------- alignment FIFO ----------------
  logic [DW-1:0] mem [ALIGN_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_addr;
  logic [AW:0]   count;
  logic          push, pop, full, empty, do_push, do_pop;
  logic [DW-1:0] head;

  assign push  = bus.i_line_vld;
  assign pop   = bus.i_base_line_vld;
  assign full  = (count == (AW+1)'(ALIGN_DEPTH));
  assign empty = (count == '0);

  // A frame-start flush empties the FIFO before this cycle's push and pop
  // are considered, so the push lands in entry 0 and the pop finds nothing.
  assign do_push = push & (frame_start | ~full | pop);
  assign do_pop  = pop & ~empty & ~frame_start;
  assign wr_addr = frame_start ? '0 : wr_ptr;
  // Underflow substitutes the base pixel, forcing a zero detail.
  assign head    = do_pop ? mem[rd_ptr] : bus.i_base_data;

  // NOTE: the storage array has no reset; count and pointers alone define
  // which entries are valid, so clearing the RAM would buy nothing.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_addr] <= bus.i_img_data;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      field_d        <= 1'b0;
      gain_q         <= GAIN_W'(1 << GAIN_FRAC);
      thr_q          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.o_fifo_ovf <= 1'b0;
      bus.o_fifo_udf <= 1'b0;
    end else begin
      field_d <= bus.i_field_vld;
      if (frame_start) begin
        gain_q         <= bus.i_detail_gain;
        thr_q          <= bus.i_noise_thr;
        wr_ptr         <= AW'(do_push);
        rd_ptr         <= '0;
        count          <= (AW+1)'(do_push);
        bus.o_fifo_ovf <= 1'b0;
        bus.o_fifo_udf <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (push & full & ~pop) bus.o_fifo_ovf <= 1'b1;
        if (pop & empty)        bus.o_fifo_udf <= 1'b1;
      end
    end
  end

  // ---------------- enhancement pipeline ----------------
  logic                 s1_vld, s1_field;
  logic [DW-1:0]        s1_orig, s1_base;
  logic                 s2_vld, s2_field;
  logic signed [DW:0]   s2_d;
  logic [DW-1:0]        s2_base;
  logic                 s3_vld, s3_field;
  logic signed [PW-1:0] s3_p;
  logic [DW-1:0]        s3_base;

  logic signed [DW:0]   diff;
  logic [DW:0]          mag;
  logic                 cored;
  logic signed [PW-1:0] d_ext, g_ext, prod, rnd_sum;
  logic signed [PW:0]   sum;
  logic [DW-1:0]        clipped;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a value held, which would infer a latch.
  always_comb begin
    diff  = $signed({1'b0, s1_orig}) - $signed({1'b0, s1_base});
    mag   = diff[DW] ? (DW+1)'(-diff) : diff;
    cored = (mag <= {1'b0, thr_q});

    d_ext   = {{(PW-DW-1){s2_d[DW]}}, s2_d};
    g_ext   = {{(PW-GAIN_W){1'b0}}, gain_q};
    prod    = d_ext * g_ext;
    rnd_sum = prod + RND;

    sum     = $signed({{(PW+1-DW){1'b0}}, s3_base}) + $signed({s3_p[PW-1], s3_p});
    clipped = sum[DW-1:0];
    if (sum[PW])             clipped = '0;
    else if (sum > PIX_MAX)  clipped = '1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld          <= 1'b0;
      s1_field        <= 1'b0;
      s1_orig         <= '0;
      s1_base         <= '0;
      s2_vld          <= 1'b0;
      s2_field        <= 1'b0;
      s2_d            <= '0;
      s2_base         <= '0;
      s3_vld          <= 1'b0;
      s3_field        <= 1'b0;
      s3_p            <= '0;
      s3_base         <= '0;
      bus.o_line_vld  <= 1'b0;
      bus.o_field_vld <= 1'b0;
      bus.o_img_data  <= '0;
    end else begin
      s1_vld          <= pop;
      s1_field        <= bus.i_base_field_vld;
      s1_orig         <= head;
      s1_base         <= bus.i_base_data;
      s2_vld          <= s1_vld;
      s2_field        <= s1_field;
      s2_d            <= cored ? '0 : diff;
      s2_base         <= s1_base;
      s3_vld          <= s2_vld;
      s3_field        <= s2_field;
      s3_p            <= rnd_sum >>> GAIN_FRAC;
      s3_base         <= s2_base;
      bus.o_line_vld  <= s3_vld;
      bus.o_field_vld <= s3_field;
      bus.o_img_data  <= s3_vld ? clipped : '0;
    end
  end

endmodule

// File: tb/tb_dde_detail_enhance.sv
// Self-checking bench for dde_detail_enhance: a queue-based reference model
// scores every output cycle; scenario tasks add directed value checks.
module tb_dde_detail_enhance;
  localparam int DW    = 14;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int GW    = 8;
  localparam int GF    = 4;
  localparam int PMAX  = (1 << DW) - 1;

  typedef struct {
    bit vld;
    bit fld;
    int data;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  dde_detail_enhance_if #(.DW(DW), .GAIN_W(GW)) bus ();

  dde_detail_enhance #(
    .DW(DW), .ALIGN_DEPTH(DEPTH), .AW(AW), .GAIN_W(GW), .GAIN_FRAC(GF)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   q[$];
  exp_t pipe[$];
  int   obs[$];
  int   src_o[$];
  int   src_b[$];
  int   m_gain, m_thr;
  bit   m_ovf, m_udf, m_prev;

  function automatic int enh(int o, int b, int g, int t);
    int d, p, r, s;
    d = o - b;
    if (d <= t && d >= -t) d = 0;
    p = d * g + (1 << (GF - 1));
    if (p >= 0) r = p / (1 << GF);
    else        r = -((-p + (1 << GF) - 1) / (1 << GF));
    s = b + r;
    if (s < 0) s = 0;
    else if (s > PMAX) s = PMAX;
    return s;
  endfunction

  // One clock: advance the model on the edge, compare all outputs 1 time unit later.
  task automatic tick();
    exp_t e, z;
    bit   fs;
    int   orig;
    z = '{1'b0, 1'b0, 0};
    @(posedge i_clk);
    if (i_rst) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_prev = 0;
      m_gain = 1 << GF; m_thr = 0;
      pipe = {z, z, z};
      e = z;
    end else begin
      fs = bus.i_field_vld && !m_prev;
      m_prev = bus.i_field_vld;
      if (fs) begin
        q.delete();
        m_ovf = 0; m_udf = 0;
        m_gain = int'(bus.i_detail_gain);
        m_thr  = int'(bus.i_noise_thr);
      end
      orig = int'(bus.i_base_data);
      if (bus.i_base_line_vld) begin
        if (fs) orig = int'(bus.i_base_data);
        else if (q.size() == 0) m_udf = 1;
        else orig = q.pop_front();
      end
      if (bus.i_line_vld) begin
        if (q.size() < DEPTH) q.push_back(int'(bus.i_img_data));
        else m_ovf = 1;
      end
      e.vld  = bus.i_base_line_vld;
      e.fld  = bus.i_base_field_vld;
      e.data = bus.i_base_line_vld ? enh(orig, int'(bus.i_base_data), m_gain, m_thr) : 0;
      pipe.push_back(e);
      e = pipe.pop_front();
    end
    #1;
    vec_cnt++;
    if (bus.o_line_vld !== e.vld) begin
      err_cnt++; $display("FAIL line_vld t=%0t got %b want %b", $time, bus.o_line_vld, e.vld);
    end
    vec_cnt++;
    if (bus.o_field_vld !== e.fld) begin
      err_cnt++; $display("FAIL field_vld t=%0t got %b want %b", $time, bus.o_field_vld, e.fld);
    end
    vec_cnt++;
    if (bus.o_img_data !== DW'(e.data)) begin
      err_cnt++; $display("FAIL img_data t=%0t got %0d want %0d", $time, bus.o_img_data, e.data);
    end
    vec_cnt++;
    if (bus.o_fifo_ovf !== m_ovf) begin
      err_cnt++; $display("FAIL fifo_ovf t=%0t got %b want %b", $time, bus.o_fifo_ovf, m_ovf);
    end
    vec_cnt++;
    if (bus.o_fifo_udf !== m_udf) begin
      err_cnt++; $display("FAIL fifo_udf t=%0t got %b want %b", $time, bus.o_fifo_udf, m_udf);
    end
    if (bus.o_line_vld === 1'b1) obs.push_back(int'(bus.o_img_data));
  endtask

  task automatic idle();
    bus.i_line_vld      = 1'b0;
    bus.i_img_data      = '0;
    bus.i_base_line_vld = 1'b0;
    bus.i_base_data     = '0;
  endtask

  // Leaves the field high so the next tick is the frame-start cycle.
  task automatic start_frame(input int g, input int t);
    idle();
    bus.i_field_vld      = 1'b0;
    bus.i_base_field_vld = 1'b0;
    repeat (2) tick();
    bus.i_detail_gain    = GW'(g);
    bus.i_noise_thr      = DW'(t);
    bus.i_field_vld      = 1'b1;
    bus.i_base_field_vld = 1'b1;
  endtask

  // Pushes src_o, pops src_b 'lag' cycles later, then drains the pipeline.
  task automatic run_line(input int n, input int lag);
    obs.delete();
    for (int c = 0; c < n + lag; c++) begin
      idle();
      if (c < n) begin
        bus.i_line_vld = 1'b1;
        bus.i_img_data = DW'(src_o[c]);
      end
      if (c >= lag) begin
        bus.i_base_line_vld = 1'b1;
        bus.i_base_data     = DW'(src_b[c - lag]);
      end
      tick();
    end
    idle();
    repeat (5) tick();
  endtask

  task automatic run_const(input int g, input int t, input int o, input int b);
    start_frame(g, t);
    src_o.delete(); src_b.delete();
    for (int i = 0; i < 6; i++) begin
      src_o.push_back(o); src_b.push_back(b);
    end
    run_line(6, 2);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    idle();
    bus.i_field_vld = 1'b0; bus.i_base_field_vld = 1'b0;
    bus.i_detail_gain = GW'(16); bus.i_noise_thr = '0;
    repeat (3) tick();
    vec_cnt++;
    if ({bus.o_line_vld, bus.o_field_vld, bus.o_fifo_ovf, bus.o_fifo_udf, bus.o_img_data} !== '0) begin
      err_cnt++; $display("FAIL reset_state got vld=%b fld=%b ovf=%b udf=%b data=%0d want all 0",
        bus.o_line_vld, bus.o_field_vld, bus.o_fifo_ovf, bus.o_fifo_udf, bus.o_img_data);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_flat();
    start_frame(16, 0);
    src_o.delete(); src_b.delete();
    for (int i = 0; i < 20; i++) begin
      src_o.push_back(1000); src_b.push_back(1000);
    end
    run_line(20, 3);
    vec_cnt++;
    if (obs.size() != 20) begin
      err_cnt++; $display("FAIL flat_count got %0d want 20", obs.size());
    end
    foreach (obs[i]) begin
      vec_cnt++;
      if (obs[i] != 1000) begin
        err_cnt++; $display("FAIL flat_pixel[%0d] got %0d want 1000", i, obs[i]);
      end
    end
  endtask

  task automatic test_detail();
    int cases [4][5] = '{'{32, 0, 1200, 1000, 1400}, '{24, 0, 900, 1000, 850},
                         '{64, 8, 1005, 1000, 1000}, '{64, 4, 1005, 1000, 1020}};
    int more  [3][5] = '{'{8, 0, 1003, 1000, 1002}, '{255, 0, 16000, 15000, 16383},
                         '{255, 0, 0, 2000, 0}};
    for (int k = 0; k < 7; k++) begin
      int c [5];
      c = (k < 4) ? cases[k] : more[k-4];
      run_const(c[0], c[1], c[2], c[3]);
      vec_cnt++;
      if (obs.size() != 6 || obs[0] != c[4] || obs[5] != c[4]) begin
        err_cnt++;
        $display("FAIL detail_case%0d g=%0d thr=%0d orig=%0d base=%0d got n=%0d first=%0d want 6x%0d",
          k, c[0], c[1], c[2], c[3], obs.size(), (obs.size() > 0) ? obs[0] : -1, c[4]);
      end
    end
  endtask

  task automatic test_fifo_flags();
    start_frame(16, 0);
    tick();
    obs.delete();
    bus.i_base_line_vld = 1'b1; bus.i_base_data = DW'(777);
    tick();
    idle();
    vec_cnt++;
    if (bus.o_fifo_udf !== 1'b1) begin
      err_cnt++; $display("FAIL udf_set got %b want 1", bus.o_fifo_udf);
    end
    repeat (5) tick();
    vec_cnt++;
    if (obs.size() != 1 || obs[0] != 777) begin
      err_cnt++; $display("FAIL udf_passthru got n=%0d want one pixel 777", obs.size());
    end

    start_frame(16, 0);
    for (int c = 0; c <= DEPTH; c++) begin
      bus.i_line_vld = 1'b1; bus.i_img_data = DW'((c * 37) % (PMAX + 1));
      tick();
    end
    idle();
    vec_cnt++;
    if (bus.o_fifo_ovf !== 1'b1 || bus.o_fifo_udf !== 1'b0) begin
      err_cnt++; $display("FAIL ovf_set got ovf=%b udf=%b want 1 0", bus.o_fifo_ovf, bus.o_fifo_udf);
    end
    obs.delete();
    for (int c = 0; c < DEPTH; c++) begin
      bus.i_base_line_vld = 1'b1; bus.i_base_data = DW'(1000);
      tick();
    end
    vec_cnt++;
    if (bus.o_fifo_udf !== 1'b0) begin
      err_cnt++; $display("FAIL full_count got udf=%b after %0d pops want 0", bus.o_fifo_udf, DEPTH);
    end
    bus.i_base_data = DW'(555);
    tick();
    idle();
    vec_cnt++;
    if (bus.o_fifo_udf !== 1'b1) begin
      err_cnt++; $display("FAIL drain_udf got %b want 1", bus.o_fifo_udf);
    end
    repeat (5) tick();
    vec_cnt++;
    if (obs.size() != DEPTH + 1 || obs[DEPTH] != 555) begin
      err_cnt++; $display("FAIL drain_tail got n=%0d want %0d ending in 555", obs.size(), DEPTH + 1);
    end
    for (int c = 0; c < DEPTH && c < obs.size(); c += 97) begin
      vec_cnt++;
      if (obs[c] != (c * 37) % (PMAX + 1)) begin
        err_cnt++; $display("FAIL drain_pixel[%0d] got %0d want %0d", c, obs[c], (c * 37) % (PMAX + 1));
      end
    end

    start_frame(16, 0);
    tick();
    vec_cnt++;
    if (bus.o_fifo_ovf !== 1'b0 || bus.o_fifo_udf !== 1'b0) begin
      err_cnt++; $display("FAIL flags_clear got ovf=%b udf=%b want 0 0", bus.o_fifo_ovf, bus.o_fifo_udf);
    end
  endtask

  task automatic test_gain_hold();
    run_const(16, 0, 1200, 1000);
    bus.i_detail_gain = GW'(32);
    src_o.delete(); src_b.delete();
    for (int i = 0; i < 6; i++) begin
      src_o.push_back(1200); src_b.push_back(1000);
    end
    run_line(6, 2);
    vec_cnt++;
    if (obs.size() != 6 || obs[0] != 1200 || obs[5] != 1200) begin
      err_cnt++; $display("FAIL gain_hold got first=%0d want 1200", (obs.size() > 0) ? obs[0] : -1);
    end
    run_const(32, 0, 1200, 1000);
    vec_cnt++;
    if (obs.size() != 6 || obs[0] != 1400) begin
      err_cnt++; $display("FAIL gain_new_frame got first=%0d want 1400", (obs.size() > 0) ? obs[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    start_frame(16, 0);
    for (int c = 0; c < 10; c++) begin
      bus.i_line_vld = 1'b1; bus.i_img_data = DW'(1200);
      bus.i_base_line_vld = (c >= 2); bus.i_base_data = DW'(1000);
      tick();
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    vec_cnt++;
    if ({bus.o_line_vld, bus.o_field_vld, bus.o_img_data} !== '0) begin
      err_cnt++; $display("FAIL reset_mid got vld=%b fld=%b data=%0d want 0",
        bus.o_line_vld, bus.o_field_vld, bus.o_img_data);
    end
    idle();
    bus.i_field_vld = 1'b0; bus.i_base_field_vld = 1'b0;
    tick();
    obs.delete();
    bus.i_base_line_vld = 1'b1; bus.i_base_data = DW'(321);
    tick();
    idle();
    vec_cnt++;
    if (bus.o_fifo_udf !== 1'b1) begin
      err_cnt++; $display("FAIL reset_empty got udf=%b want 1", bus.o_fifo_udf);
    end
    repeat (5) tick();
    vec_cnt++;
    if (obs.size() != 1 || obs[0] != 321) begin
      err_cnt++; $display("FAIL reset_empty_pix got n=%0d want one pixel 321", obs.size());
    end
    run_const(32, 0, 1200, 1000);
    vec_cnt++;
    if (obs.size() != 6 || obs[0] != 1400) begin
      err_cnt++; $display("FAIL reset_restart got first=%0d want 1400", (obs.size() > 0) ? obs[0] : -1);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int n, lag, o, b;
      n   = $urandom_range(20, 80);
      lag = $urandom_range(1, 6);
      start_frame($urandom_range(0, 255), $urandom_range(0, 300));
      src_o.delete(); src_b.delete();
      for (int i = 0; i < n; i++) begin
        o = $urandom_range(0, PMAX);
        b = o + int'($urandom_range(0, 800)) - 400;
        if ($urandom_range(0, 9) == 0) b = $urandom_range(0, PMAX);
        if (b < 0) b = 0;
        if (b > PMAX) b = PMAX;
        src_o.push_back(o); src_b.push_back(b);
      end
      run_line(n, lag);
      vec_cnt++;
      if (obs.size() != n) begin
        err_cnt++; $display("FAIL random_count frame %0d got %0d want %0d", f, obs.size(), n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_detail();
    test_fifo_flags();
    test_gain_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
